// File: rtl/pp_buf_pkg.sv
// Shared types for the ping-pong bank writer: per-bank state and frame length clamp.
package pp_buf_pkg;

    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    // A zero or oversized frame length means "fill the whole bank".
    function automatic logic [31:0] frame_len_clamp(input logic [31:0] len, input logic [31:0] depth);
        return (len == 32'd0 || len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/pp_bank_ctrl.sv
// One ping-pong bank: EMPTY/FILLING/FULL tracking, latched frame length, registered full flag.
// Full flag lags the internal FULL state by one cycle so the last BRAM write lands first.
module pp_bank_ctrl
    import pp_buf_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          i_accept,
    input  logic [AW-1:0] i_wptr,
    input  logic [AW:0]   i_frame_len,
    input  logic          i_release,
    output logic          o_can_accept,
    output logic          o_last,
    output logic          o_full
);

    bank_state_e r_state;
    bank_state_e w_state_nxt;
    logic [AW:0] r_len_q;
    logic [AW:0] w_len_eff;
    logic [AW:0] w_cur_len;
    logic        w_start;
    logic        r_full;

    assign w_len_eff = (AW+1)'(frame_len_clamp(32'(i_frame_len), 32'(DEPTH)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (i_accept) w_state_nxt = o_last ? FULL : FILLING;
                FILLING: if (i_accept && o_last) w_state_nxt = FULL;
                FULL: begin
                    // A release coinciding with a word immediately starts the next frame.
                    if (i_release) w_state_nxt = i_accept ? (o_last ? FULL : FILLING) : EMPTY;
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        w_start      = (r_state == EMPTY) || (r_state == FULL && i_release);
        o_can_accept = (r_state != FULL) || i_release;
        w_cur_len    = w_start ? w_len_eff : r_len_q;
        o_last       = i_accept && ({1'b0, i_wptr} == w_cur_len - (AW+1)'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_q <= '0;
            r_full  <= 1'b0;
        end else begin
            if (i_accept && w_start) r_len_q <= w_len_eff;
            r_full <= !flush && (r_state == FULL) && !i_release;
        end
    end

    assign o_full = r_full;

endmodule

// File: rtl/pp_bank_writer.sv
// Steers an unstalled word stream into two BRAM banks, one frame per bank; writes land 1 cycle later.
// No backpressure: words that find their target bank still FULL are dropped and flag sticky overflow.
module pp_bank_writer
    import pp_buf_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [AW:0]   frame_len,
    input  logic [DW-1:0] in_data,
    input  logic          in_we,
    output logic          BRAM0_we,
    output logic          BRAM0_w_en,
    output logic [AW-1:0] BRAM0_w_addr,
    output logic [DW-1:0] BRAM0_wdata,
    output logic          BRAM1_we,
    output logic          BRAM1_w_en,
    output logic [AW-1:0] BRAM1_w_addr,
    output logic [DW-1:0] BRAM1_wdata,
    output logic [1:0]    bank_full,
    input  logic [1:0]    bank_release,
    output logic          wr_bank,
    output logic          frame_done,
    output logic          overflow
);

    logic [AW-1:0] r_wptr;
    logic          r_wr_bank;
    logic          r_overflow;
    logic          r_done_d;
    logic          r_frame_done;
    logic          r_b0_we;
    logic          r_b1_we;
    logic [AW-1:0] r_b0_addr;
    logic [AW-1:0] r_b1_addr;
    logic [DW-1:0] r_b0_data;
    logic [DW-1:0] r_b1_data;

    logic [NUM_BANKS-1:0] w_can;
    logic [NUM_BANKS-1:0] w_last;
    logic [NUM_BANKS-1:0] w_acc;
    logic [NUM_BANKS-1:0] w_full;
    logic                 w_accept;
    logic                 w_frame_end;

    assign w_accept    = in_we && !flush && w_can[r_wr_bank];
    assign w_acc[0]    = w_accept && !r_wr_bank;
    assign w_acc[1]    = w_accept && r_wr_bank;
    assign w_frame_end = |w_last;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        pp_bank_ctrl #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ctrl (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush        (flush),
            .i_accept     (w_acc[g]),
            .i_wptr       (r_wptr),
            .i_frame_len  (frame_len),
            .i_release    (bank_release[g]),
            .o_can_accept (w_can[g]),
            .o_last       (w_last[g]),
            .o_full       (w_full[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_wr_bank    <= 1'b0;
            r_overflow   <= 1'b0;
            r_done_d     <= 1'b0;
            r_frame_done <= 1'b0;
            r_b0_we      <= 1'b0;
            r_b1_we      <= 1'b0;
            r_b0_addr    <= '0;
            r_b1_addr    <= '0;
            r_b0_data    <= '0;
            r_b1_data    <= '0;
        end else if (flush) begin
            r_wptr       <= '0;
            r_wr_bank    <= 1'b0;
            r_overflow   <= 1'b0;
            r_done_d     <= 1'b0;
            r_frame_done <= 1'b0;
            r_b0_we      <= 1'b0;
            r_b1_we      <= 1'b0;
        end else begin
            r_b0_we <= w_acc[0];
            r_b1_we <= w_acc[1];
            if (w_acc[0]) begin
                r_b0_addr <= r_wptr;
                r_b0_data <= in_data;
            end
            if (w_acc[1]) begin
                r_b1_addr <= r_wptr;
                r_b1_data <= in_data;
            end
            if (w_accept) r_wptr <= w_frame_end ? '0 : r_wptr + AW'(1);
            if (w_frame_end) r_wr_bank <= !r_wr_bank;
            if (in_we && !w_accept) r_overflow <= 1'b1;
            // Two-stage delay keeps frame_done aligned with the registered bank_full rise.
            r_done_d     <= w_frame_end;
            r_frame_done <= r_done_d;
        end
    end

    assign BRAM0_we     = r_b0_we;
    assign BRAM0_w_en   = r_b0_we;
    assign BRAM0_w_addr = r_b0_addr;
    assign BRAM0_wdata  = r_b0_data;
    assign BRAM1_we     = r_b1_we;
    assign BRAM1_w_en   = r_b1_we;
    assign BRAM1_w_addr = r_b1_addr;
    assign BRAM1_wdata  = r_b1_data;
    assign bank_full    = w_full;
    assign wr_bank      = r_wr_bank;
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_pp_bank_writer.sv
// Self-checking bench for pp_bank_writer against a frame-level reference model.
module tb_pp_bank_writer;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [AW:0]   frame_len = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_we = 1'b0;
    logic [1:0]    bank_release = 2'b00;
    logic          BRAM0_we, BRAM0_w_en, BRAM1_we, BRAM1_w_en;
    logic [AW-1:0] BRAM0_w_addr, BRAM1_w_addr;
    logic [DW-1:0] BRAM0_wdata, BRAM1_wdata;
    logic [1:0]    bank_full;
    logic          wr_bank, frame_done, overflow;

    always #5 clk = ~clk;

    pp_bank_writer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .frame_len    (frame_len),
        .in_data      (in_data),
        .in_we        (in_we),
        .BRAM0_we     (BRAM0_we),
        .BRAM0_w_en   (BRAM0_w_en),
        .BRAM0_w_addr (BRAM0_w_addr),
        .BRAM0_wdata  (BRAM0_wdata),
        .BRAM1_we     (BRAM1_we),
        .BRAM1_w_en   (BRAM1_w_en),
        .BRAM1_w_addr (BRAM1_w_addr),
        .BRAM1_wdata  (BRAM1_wdata),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .wr_bank      (wr_bank),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which banks hold a finished frame, where the writer is inside its frame.
    logic [1:0] m_held;
    int         m_cnt, m_bank;
    int         m_len[2];
    logic       m_ovf, m_pend;

    logic          e_we0, e_we1, e_done, e_ovf;
    logic [1:0]    e_full;
    logic [AW-1:0] e_addr0, e_addr1;
    logic [DW-1:0] e_data0, e_data1;
    logic [8:0]    exp_ctl;

    wire [8:0]       obs_ctl = {BRAM0_we, BRAM0_w_en, BRAM1_we, BRAM1_w_en, overflow, wr_bank, bank_full, frame_done};
    wire [AW+DW-1:0] obs_w0  = {BRAM0_w_addr, BRAM0_wdata};
    wire [AW+DW-1:0] obs_w1  = {BRAM1_w_addr, BRAM1_wdata};

    task automatic model_reset();
        m_held = 2'b00; m_cnt = 0; m_bank = 0; m_len[0] = 0; m_len[1] = 0;
        m_ovf = 1'b0; m_pend = 1'b0;
        e_we0 = 1'b0; e_we1 = 1'b0; e_done = 1'b0; e_ovf = 1'b0; e_full = 2'b00;
        e_addr0 = '0; e_addr1 = '0; e_data0 = '0; e_data1 = '0;
        exp_ctl = '0;
    endtask

    // Drive one cycle of inputs, advance the model, and leave the bench at posedge+1.
    task automatic step(input logic fl, input logic we, input logic [DW-1:0] d, input logic [1:0] rel);
        int flen;
        e_we0  = 1'b0;
        e_we1  = 1'b0;
        e_full = m_held & ~rel & {2{~fl}};
        e_done = m_pend & ~fl;
        m_pend = 1'b0;
        if (fl) begin
            m_held = 2'b00; m_cnt = 0; m_bank = 0; m_ovf = 1'b0;
        end else begin
            m_held = m_held & ~rel;
            if (we) begin
                if (m_held[m_bank]) begin
                    m_ovf = 1'b1;
                end else begin
                    if (m_cnt == 0) begin
                        flen = int'(frame_len);
                        m_len[m_bank] = (flen == 0 || flen > DEPTH) ? DEPTH : flen;
                    end
                    if (m_bank == 0) begin
                        e_we0 = 1'b1; e_addr0 = AW'(m_cnt); e_data0 = d;
                    end else begin
                        e_we1 = 1'b1; e_addr1 = AW'(m_cnt); e_data1 = d;
                    end
                    m_cnt++;
                    if (m_cnt == m_len[m_bank]) begin
                        m_held[m_bank] = 1'b1; m_cnt = 0; m_bank = 1 - m_bank; m_pend = 1'b1;
                    end
                end
            end
        end
        e_ovf   = m_ovf;
        exp_ctl = {e_we0, e_we0, e_we1, e_we1, e_ovf, 1'(m_bank), e_full, e_done};
        flush = fl; in_we = we; in_data = d; bank_release = rel;
        @(posedge clk); #1;
        flush = 1'b0; in_we = 1'b0; bank_release = 2'b00;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({obs_ctl, obs_w0, obs_w1} !== '0) begin
            n_err++; $display("FAIL reset_values got ctl=%b w0=%h w1=%h want all zero", obs_ctl, obs_w0, obs_w1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({obs_ctl, obs_w0, obs_w1} !== '0) begin
            n_err++; $display("FAIL reset_release got ctl=%b w0=%h w1=%h want all zero", obs_ctl, obs_w0, obs_w1);
        end
    endtask

    task automatic test_basic();
        int dones = 0;
        frame_len = (AW+1)'(4);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, i < 8, DW'(i), 2'b00);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL basic_ctl i=%0d got %b want %b", i, obs_ctl, exp_ctl); end
            if (e_we0) begin n_cmp++; if (obs_w0 !== {e_addr0, e_data0}) begin n_err++; $display("FAIL basic_w0 i=%0d got %h want %h", i, obs_w0, {e_addr0, e_data0}); end end
            if (e_we1) begin n_cmp++; if (obs_w1 !== {e_addr1, e_data1}) begin n_err++; $display("FAIL basic_w1 i=%0d got %h want %h", i, obs_w1, {e_addr1, e_data1}); end end
            if (frame_done) dones++;
            if (i == 4) begin n_cmp++; if (bank_full !== 2'b01) begin n_err++; $display("FAIL basic_full_a got %b want 01", bank_full); end end
            if (i == 8) begin n_cmp++; if (bank_full !== 2'b11) begin n_err++; $display("FAIL basic_full_b got %b want 11", bank_full); end end
        end
        n_cmp++;
        if (dones != 2) begin n_err++; $display("FAIL basic_done_count got %0d want 2", dones); end
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b1, 32'hA5A5_0001, 2'b00);
        n_cmp++;
        if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL ovf_drop_ctl got %b want %b", obs_ctl, exp_ctl); end
        n_cmp++;
        if ({BRAM0_we, BRAM1_we, overflow} !== 3'b001) begin n_err++; $display("FAIL ovf_drop got we0,we1,ovf=%b want 001", {BRAM0_we, BRAM1_we, overflow}); end
        step(1'b0, 1'b0, '0, 2'b00);
        n_cmp++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        step(1'b0, 1'b1, 32'h5A5A_0002, 2'b01);
        n_cmp++;
        if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL ovf_rel_ctl got %b want %b", obs_ctl, exp_ctl); end
        n_cmp++;
        if ({BRAM0_we, BRAM0_w_addr, BRAM0_wdata, overflow} !== {1'b1, AW'(0), 32'h5A5A_0002, 1'b1}) begin
            n_err++; $display("FAIL ovf_release_write got we=%b addr=%0d data=%h ovf=%b want 1 0 5a5a0002 1", BRAM0_we, BRAM0_w_addr, BRAM0_wdata, overflow);
        end
    endtask

    task automatic test_len_zero();
        step(1'b1, 1'b0, '0, 2'b00);
        frame_len = '0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            step(1'b0, i < DEPTH, $urandom, 2'b00);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL len0_ctl i=%0d got %b want %b", i, obs_ctl, exp_ctl); end
            if (e_we0) begin n_cmp++; if (obs_w0 !== {e_addr0, e_data0}) begin n_err++; $display("FAIL len0_w0 i=%0d got %h want %h", i, obs_w0, {e_addr0, e_data0}); end end
            if (i == DEPTH - 1) begin
                n_cmp++;
                if ({BRAM0_we, BRAM0_w_addr, wr_bank} !== {1'b1, AW'(DEPTH - 1), 1'b1}) begin
                    n_err++; $display("FAIL len0_last got we=%b addr=%0d bank=%b want 1 %0d 1", BRAM0_we, BRAM0_w_addr, wr_bank, DEPTH - 1);
                end
            end
        end
    endtask

    task automatic test_len_change();
        int n0 = 0, n1 = 0;
        step(1'b1, 1'b0, '0, 2'b00);
        frame_len = (AW+1)'(4);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) frame_len = (AW+1)'(2);
            step(1'b0, i < 6, $urandom, 2'b00);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL lenchg_ctl i=%0d got %b want %b", i, obs_ctl, exp_ctl); end
            if (e_we0) begin n_cmp++; if (obs_w0 !== {e_addr0, e_data0}) begin n_err++; $display("FAIL lenchg_w0 i=%0d got %h want %h", i, obs_w0, {e_addr0, e_data0}); end end
            if (e_we1) begin n_cmp++; if (obs_w1 !== {e_addr1, e_data1}) begin n_err++; $display("FAIL lenchg_w1 i=%0d got %h want %h", i, obs_w1, {e_addr1, e_data1}); end end
            if (BRAM0_we) n0++;
            if (BRAM1_we) n1++;
        end
        n_cmp++;
        if (n0 != 4 || n1 != 2) begin n_err++; $display("FAIL lenchg_counts got %0d/%0d want 4/2", n0, n1); end
    endtask

    task automatic test_flush();
        step(1'b1, 1'b0, '0, 2'b00);
        frame_len = (AW+1)'(4);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, DW'(100 + i), 2'b00);
        step(1'b0, 1'b0, '0, 2'b00);
        n_cmp++;
        if (bank_full !== 2'b01) begin n_err++; $display("FAIL flush_pre got bank_full=%b want 01", bank_full); end
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 2'b00);
        n_cmp++;
        if ({bank_full, wr_bank, overflow, BRAM0_we, BRAM1_we} !== 6'b0) begin
            n_err++; $display("FAIL flush_clear got full=%b bank=%b ovf=%b we=%b%b want all 0", bank_full, wr_bank, overflow, BRAM0_we, BRAM1_we);
        end
        step(1'b0, 1'b1, 32'h0000_00C3, 2'b00);
        n_cmp++;
        if ({BRAM0_we, BRAM0_w_addr, BRAM0_wdata} !== {1'b1, AW'(0), 32'h0000_00C3}) begin
            n_err++; $display("FAIL flush_next got we=%b addr=%0d data=%h want 1 0 000000c3", BRAM0_we, BRAM0_w_addr, BRAM0_wdata);
        end
    endtask

    task automatic test_async_reset();
        in_we = 1'b1; in_data = 32'h1234_5678;
        @(posedge clk); #3;
        n_cmp++;
        if (BRAM0_we !== 1'b1) begin n_err++; $display("FAIL areset_pre got we0=%b want 1", BRAM0_we); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({obs_ctl, obs_w0, obs_w1} !== '0) begin
            n_err++; $display("FAIL areset_now got ctl=%b w0=%h w1=%h want all zero", obs_ctl, obs_w0, obs_w1);
        end
        in_we = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 32'h0000_0077, 2'b00);
        n_cmp++;
        if ({obs_ctl, obs_w0} !== {exp_ctl, e_addr0, e_data0} || BRAM0_w_addr !== AW'(0)) begin
            n_err++; $display("FAIL areset_next got ctl=%b w0=%h want ctl=%b w0=%h", obs_ctl, obs_w0, exp_ctl, {e_addr0, e_data0});
        end
    endtask

    task automatic test_random();
        step(1'b1, 1'b0, '0, 2'b00);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) frame_len = (AW+1)'($urandom_range(0, 2 * DEPTH - 1));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom,
                 {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0});
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL rand_ctl i=%0d got %b want %b", i, obs_ctl, exp_ctl); end
            if (e_we0) begin n_cmp++; if (obs_w0 !== {e_addr0, e_data0}) begin n_err++; $display("FAIL rand_w0 i=%0d got %h want %h", i, obs_w0, {e_addr0, e_data0}); end end
            if (e_we1) begin n_cmp++; if (obs_w1 !== {e_addr1, e_data1}) begin n_err++; $display("FAIL rand_w1 i=%0d got %h want %h", i, obs_w1, {e_addr1, e_data1}); end end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_len_zero();
        test_len_change();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pp_bank_writer.md
# pp_bank_writer

Ping-pong bank write controller between the DDR AXI read engine's FIFO-style output stream (`rd_fifo_data` / `rd_fifo_we`) and the two simple-dual-port BRAM banks of the ping-pong buffer. It steers incoming words into BRAM0 and BRAM1 alternately, one frame of `frame_len` words per bank. It publishes per-bank full flags to the downstream consumer, which frees a bank by pulsing a release. The input stream has no backpressure, so a word that finds no free bank is dropped and flagged.

## Interface
- `DW`, 32, data width of the input stream and of both banks
- `DEPTH`, 1024, words per bank
- `AW`, `$clog2(DEPTH)`, bank address width
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of all bank state, pointers and overflow
- `frame_len`  in  AW+1  words per frame; 0 or any value above DEPTH means DEPTH
- `in_data`  in  DW  stream word (from `rd_fifo_data`)
- `in_we`  in  1  stream word valid (from `rd_fifo_we`); no ready, never stalled
- `BRAM0_we`, `BRAM0_w_en`  out  1 each  bank 0 write strobe and enable (identical)
- `BRAM0_w_addr`  out  AW  bank 0 write address
- `BRAM0_wdata`  out  DW  bank 0 write data
- `BRAM1_we`, `BRAM1_w_en`, `BRAM1_w_addr`, `BRAM1_wdata`: same as bank 0, for bank 1
- `bank_full`  out  2  bit i high means bank i holds a complete frame and is readable
- `bank_release`  in  2  consumer pulse; bit i returns bank i to EMPTY
- `wr_bank`  out  1  bank currently targeted by the writer
- `frame_done`  out  1  one-cycle pulse when a bank becomes FULL
- `overflow`  out  1  sticky; set when a word is dropped

## Operation
- Each bank has its own state machine with three states.
  - EMPTY -> FILLING: on the first accepted word.
  - FILLING -> FULL: on the accepted word with index `len_q-1`.
  - FULL -> EMPTY: on `bank_release[i]`.
- `len_q` is `frame_len` sampled when a bank leaves EMPTY. A change to `frame_len` mid-frame has no effect on that frame.
- Word acceptance: a word on `in_we` targets bank `wr_bank`. It is accepted if that bank is EMPTY or FILLING, or if it is FULL with `bank_release[wr_bank]` high in the same cycle (release wins, and the word starts a new frame).
- If the word is not accepted, it is dropped, `overflow` is set, and no BRAM strobe is issued.
- The write pointer `wptr` (width AW) resets to 0 at each frame start and increments per accepted word. It never wraps inside a frame.
- At frame end, `wptr` returns to 0 and `wr_bank` toggles. The first frame goes to bank 0.
- `bank_release` on a bank that is not FULL is ignored.
- `flush` has priority over every other input. It clears both banks to EMPTY and clears `wptr`, `wr_bank`, `overflow` and all strobes. A word arriving in the flush cycle is discarded without setting `overflow`.
- Reset mid-frame: the partial frame is lost and the next word goes to bank 0, address 0.

## Timing
- Reset values: all strobes 0, addresses 0, wdata 0, `bank_full`=00, `wr_bank`=0, `frame_done`=0, `overflow`=0.
- BRAM outputs are registered. A word accepted in cycle N produces `BRAMx_we`/`w_en` high in N+1, with address and data valid in that same cycle.
- `bank_full[i]` and `frame_done` assert in N+2, where N is the cycle of the last word. This guarantees the final write has landed before the consumer issues any read.
- Release in cycle R clears `bank_full[i]` in R+1.
- `overflow` rises in the cycle after the dropped word.
- Back-to-back `in_we` is sustained at 1 word/cycle, including across the bank switch, with no bubble.

## Structure
- Package `pp_buf_pkg` holds the bank state enum {EMPTY, FILLING, FULL} and the frame length clamp helper function.
- One sub-module, `pp_bank_ctrl`, instantiated twice. It contains a bank's state register, `len_q`, and its full/release logic.
- The top level holds `wptr`, `wr_bank`, the acceptance arbitration, the output registers and `overflow`.

## Test plan
- Reset, then `frame_len`=4 and 8 back-to-back words 0..7 -> BRAM0 gets addresses 0..3 with data 0..3, BRAM1 gets addresses 0..3 with data 4..7. `bank_full` shows 01 two cycles after word 3 and 11 two cycles after word 7. `frame_done` pulses twice.
- Both banks full, one more word -> no BRAM strobe, `overflow`=1 and it stays set. Then `bank_release`=01 coincident with the next word -> that word is written to BRAM0 address 0 and `overflow` stays 1.
- `frame_len`=0 -> the frame holds DEPTH words. The last write goes to address DEPTH-1, then `wr_bank` toggles.
- `frame_len` changed from 4 to 2 after the second word of frame 0 -> frame 0 still holds 4 words and frame 1 holds 2.
- `flush` asserted while bank 1 is FILLING at `wptr`=3 with bank 0 FULL -> next cycle `bank_full`=00 and `wr_bank`=0, and the next word goes to BRAM0 address 0.
- `rst_n` deasserted asynchronously mid-write -> all outputs reach their reset values immediately, without waiting for a clock edge.
